mem_port_arbiter: RTL

//  Shares the single data/address port of the processor memory among three requesters:
//  0 = instruction fetch, 1 = processor load/store, 2 = external debug/dump engine.

---
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Three-way round-robin arbiter that owns the processor memory port: fetch (0),
// load/store (1) and debug (2) take turns, one transaction at a time.
module mem_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0]            req,
    input  logic [2:0]            we,
    input  logic [3*ADDR_W-1:0]   addr,
    input  logic [3*DATA_W-1:0]   wdata,
    output logic [2:0]            gnt,
    output logic [2:0]            ack,
    output logic [DATA_W-1:0]     rdata,
    output logic                  busy,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_wren,
    output logic                  mem_rden,
    input  logic [DATA_W-1:0]     mem_q
);

    localparam int CNT_W = (READ_LAT < 2) ? 1 : $clog2(READ_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_last;
    logic [1:0]          r_win;
    logic [1:0]          w_win;
    logic                w_any;
    logic [2:0]          w_win_onehot;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   w_addr_arr  [3];
    logic [DATA_W-1:0]   w_wdata_arr [3];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_unpack
            assign w_addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
            assign w_wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Search starts just after the last winner, so every requester is at most
    // two transactions away from service.
    always_comb begin
        w_win = 2'd0;
        w_any = |req;
        case (r_last)
            2'd0: begin
                if (req[1])      w_win = 2'd1;
                else if (req[2]) w_win = 2'd2;
                else             w_win = 2'd0;
            end
            2'd1: begin
                if (req[2])      w_win = 2'd2;
                else if (req[0]) w_win = 2'd0;
                else             w_win = 2'd1;
            end
            default: begin
                if (req[0])      w_win = 2'd0;
                else if (req[1]) w_win = 2'd1;
                else             w_win = 2'd2;
            end
        endcase
    end

    assign w_win_onehot = 3'b001 << r_win;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Strobes, grant and ack decode straight from state so an async reset
    // removes them without waiting for a clock edge.
    always_comb begin
        w_state_next = r_state;
        gnt          = 3'b000;
        ack          = 3'b000;
        mem_wren     = 1'b0;
        mem_rden     = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_any) begin
                    w_state_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                gnt          = w_win_onehot;
                mem_wren     = r_we;
                mem_rden     = ~r_we;
                w_state_next = r_we ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                gnt = w_win_onehot;
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = S_RESP;
                end
            end
            default: begin
                gnt          = w_win_onehot;
                ack          = w_win_onehot;
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last  <= 2'd2;
            r_win   <= 2'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_win   <= w_win;
                        r_last  <= w_win;
                        r_we    <= we[w_win];
                        r_addr  <= w_addr_arr[w_win];
                        r_wdata <= w_wdata_arr[w_win];
                    end
                end
                S_ACCESS: begin
                    r_cnt <= CNT_W'(READ_LAT);
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_rdata <= mem_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rdata     = r_rdata;

endmodule
